dcs_host_driver: RTL and testbench
==================================

// Module: dcs_host_driver
// PURPOSE
//  Host-side initiator for the DCSformer accelerator port. Buffers one job: an 8x16 byte matrix I
//  and an 8-byte weight vector W, loaded through a byte write port. On start, streams I, waits for
//  the w_ready pulse, streams W, then captures the 8 x 32-bit results into a readable bank.
//  Sits between the system bus shim and the accelerator; also serves as the bench-side driver.
// PARAMETERS
//  N_ROWS      8     rows of I; number of W bytes and results
//  N_COLS      16    columns of I
//  TIMEOUT_CYC 1024  wait limit for w_ready / first o_valid (used only with DCS_HOST_TIMEOUT_EN)
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   reset, asynchronous, active-low
//  ld_we        in   1   buffer write strobe
//  ld_sel       in   1   0 = I buffer, 1 = W buffer
//  ld_addr      in   7   byte address: I = row*16+col (0..127); W = 0..7 (bits [6:3] ignored)
//  ld_data      in   8   byte to write
//  start        in   1   begin job (one-cycle pulse)
//  busy         out  1   high from the cycle after an accepted start until done
//  done         out  1   one-cycle pulse when all 8 results are captured
//  err          out  1   sticky timeout flag, cleared by next accepted start (DCS_HOST_TIMEOUT_EN only)
//  res_addr     in   3   result index
//  res_data     out  32  result[res_addr], combinational read of the result bank
//  acc_i_valid  out  1   I stream valid
//  acc_i_data   out  8   I stream byte
//  acc_w_ready  in   1   accelerator weight-ready pulse (one cycle)
//  acc_w_valid  out  1   W stream valid
//  acc_w_data   out  8   W stream byte
//  acc_o_valid  in   1   result valid
//  acc_o_data   in   32  result word
// BEHAVIOUR
//  Reset: busy=done=err=0, acc_i_valid=acc_w_valid=0, acc_*_data=0, state IDLE, result bank 0.
//  FSM: IDLE -> SEND_I -> WAIT_WR -> SEND_W -> WAIT_O -> COLLECT -> DONE -> IDLE.
//  IDLE: start accepted -> SEND_I next cycle. ld_we honoured only in IDLE or DONE.
//  SEND_I: acc_i_valid high for exactly 128 consecutive cycles; bytes in row-major order I[0][0]..I[7][15].
//    The first byte is presented in the cycle after start is accepted. No gaps.
//  WAIT_WR: all outputs idle. acc_w_ready is sampled here and in the last SEND_I cycle; the pulse is latched.
//  SEND_W: begins in the cycle after the latched pulse. acc_w_valid is high for 8 consecutive cycles
//    with W[0]..W[7]. acc_w_valid is never driven before the pulse is seen.
//  WAIT_O: on the first acc_o_valid -> COLLECT; that word is stored as result[0].
//  COLLECT: each acc_o_valid cycle stores the word at index 0..7.
//    If o_valid drops mid-burst, the index holds and the FSM waits.
//  DONE: one cycle after the 8th word is stored, done=1 for one cycle and busy=0; then IDLE.
//  start while busy: ignored. acc_o_valid or acc_w_ready outside its waiting state: ignored.
//  Reset mid-job: all valids drop immediately (async); the buffers keep their contents, the result bank clears.
//  Latency: start@T -> last I byte @T+128; SEND_W starts at (w_ready cycle)+1.
// CONFIGURATION
//  DCS_HOST_TIMEOUT_EN defined:
//    A counter runs in WAIT_WR and WAIT_O. Reaching TIMEOUT_CYC sets err=1, pulses done, and returns to IDLE.
//    Partial results are retained.
//  Not defined: no counter; the FSM waits indefinitely; err tied to 0.
// STRUCTURE
//  dcs_pkg: state enum typedef, N_ROWS/N_COLS, I_BYTES=128, W_BYTES=8, OUT_W=32, result word typedef.
//  Sub-module dcs_byte_streamer: buffer + index counter + valid generation, instantiated twice
//    (I with depth 128, W with depth 8). The top module holds the FSM, the result bank and the timeout.
// TESTING (bench includes a behavioural DCSformer model)
//  I all 0x01, W all 0x01 -> every result 128 (IIT all 16, none below the average).
//  I[r][r]=1, else 0; W={1..8} -> result[r]=r+1 (off-diagonal 0; average rounds to 0).
//  Model delays w_ready by 40 cycles -> acc_w_valid stays 0 until the cycle after the pulse, then 8 cycles exactly.
//  Model stalls o_valid for 3 cycles after word 4 -> all 8 words correct, done once.
//  rst_n asserted during SEND_I byte 60 -> valids 0 the same cycle; a restart reproduces the full 128-byte stream.
//  TIMEOUT_EN, TIMEOUT_CYC=16, w_ready never sent -> err=1 and done after 16 WAIT_WR cycles; next start clears err.

Source files
------------

// File: rtl/dcs_pkg.sv
// Shared types and sizes for the DCSformer host driver: job geometry, result word and FSM states.
package dcs_pkg;

    localparam int unsigned N_ROWS  = 8;
    localparam int unsigned N_COLS  = 16;
    localparam int unsigned I_BYTES = N_ROWS * N_COLS;
    localparam int unsigned W_BYTES = N_ROWS;
    localparam int unsigned OUT_W   = 32;

    typedef logic [OUT_W-1:0] out_word_t;

    typedef enum logic [2:0] {
        StIdle,
        StSendI,
        StWaitWr,
        StSendW,
        StWaitO,
        StCollect,
        StDone
    } dcs_state_e;

endpackage

// File: rtl/dcs_byte_streamer.sv
// Byte buffer with a read index that walks 0..Depth-1 while run_i is high, then wraps to 0.
// The buffer has no reset so a job can be replayed after a mid-job reset without reloading.
module dcs_byte_streamer #(
    parameter int unsigned Depth = 8,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  logic [7:0]       wr_data_i,
    input  logic             run_i,
    output logic             valid_o,
    output logic [7:0]       data_o,
    output logic             last_o
);

    logic [7:0]       mem_q [Depth];
    logic [AddrW-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign valid_o = run_i;
    assign data_o  = run_i ? mem_q[idx_q] : 8'h00;
    assign last_o  = run_i && (idx_q == AddrW'(Depth - 1));

    always_comb begin
        idx_d = idx_q;
        if (run_i) begin
            idx_d = last_o ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/dcs_host_driver.sv
// Host-side initiator for the DCSformer port: streams I, waits for w_ready, streams W, collects 8
// result words. Define DCS_HOST_TIMEOUT_EN to bound the w_ready / first o_valid waits (sets err).
module dcs_host_driver
    import dcs_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_we_i,
    input  logic        ld_sel_i,
    input  logic [6:0]  ld_addr_i,
    input  logic [7:0]  ld_data_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    input  logic [2:0]  res_addr_i,
    output logic [31:0] res_data_o,
    output logic        acc_i_valid_o,
    output logic [7:0]  acc_i_data_o,
    input  logic        acc_w_ready_i,
    output logic        acc_w_valid_o,
    output logic [7:0]  acc_w_data_o,
    input  logic        acc_o_valid_i,
    input  logic [31:0] acc_o_data_i
);

    dcs_state_e st_q, st_d;
    logic       ld_en, start_ok, send_i, send_w, store;
    logic       i_last, w_last, tmo_hit;
    logic [2:0] ridx_q, ridx_d;
    out_word_t  bank_q [N_ROWS];

    // Buffers are writable only while no stream is reading them.
    assign ld_en    = ld_we_i && (st_q == StIdle || st_q == StDone);
    assign start_ok = start_i && (st_q == StIdle);
    assign busy_o   = (st_q != StIdle) && (st_q != StDone);

    dcs_byte_streamer #(
        .Depth(I_BYTES)
    ) u_i_stream (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (ld_en && !ld_sel_i),
        .wr_addr_i(ld_addr_i),
        .wr_data_i(ld_data_i),
        .run_i    (send_i),
        .valid_o  (acc_i_valid_o),
        .data_o   (acc_i_data_o),
        .last_o   (i_last)
    );

    dcs_byte_streamer #(
        .Depth(W_BYTES)
    ) u_w_stream (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (ld_en && ld_sel_i),
        .wr_addr_i(ld_addr_i[2:0]),
        .wr_data_i(ld_data_i),
        .run_i    (send_w),
        .valid_o  (acc_w_valid_o),
        .data_o   (acc_w_data_o),
        .last_o   (w_last)
    );

    always_comb begin
        st_d   = st_q;
        send_i = 1'b0;
        send_w = 1'b0;
        store  = 1'b0;
        done_o = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (start_i) st_d = StSendI;
            end
            StSendI: begin
                send_i = 1'b1;
                // A pulse in the final I cycle skips the wait so W follows it directly.
                if (i_last) st_d = acc_w_ready_i ? StSendW : StWaitWr;
            end
            StWaitWr: begin
                if (acc_w_ready_i) st_d = StSendW;
                else if (tmo_hit)  st_d = StDone;
            end
            StSendW: begin
                send_w = 1'b1;
                if (w_last) st_d = StWaitO;
            end
            StWaitO: begin
                if (acc_o_valid_i) begin
                    store = 1'b1;
                    st_d  = StCollect;
                end else if (tmo_hit) begin
                    st_d = StDone;
                end
            end
            StCollect: begin
                if (acc_o_valid_i) begin
                    store = 1'b1;
                    if (ridx_q == 3'(N_ROWS - 1)) st_d = StDone;
                end
            end
            StDone: begin
                done_o = 1'b1;
                st_d   = StIdle;
            end
            default: st_d = StIdle;
        endcase
    end

    always_comb begin
        ridx_d = ridx_q;
        if (start_ok)   ridx_d = '0;
        else if (store) ridx_d = ridx_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= StIdle;
            ridx_q <= '0;
        end else begin
            st_q   <= st_d;
            ridx_q <= ridx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_ROWS; i++) bank_q[i] <= '0;
        end else if (store) begin
            bank_q[ridx_q] <= acc_o_data_i;
        end
    end

    assign res_data_o = bank_q[res_addr_i];

`ifdef DCS_HOST_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;

    always_comb begin
        tmo_d = '0;
        if (st_q == StWaitWr || st_q == StWaitO) tmo_d = tmo_q + 1'b1;
        err_d = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end else if (st_d == StDone && (st_q == StWaitWr || st_q == StWaitO)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYC - 1));
    assign err_o   = err_q;
`else
    assign tmo_hit = 1'b0;
    assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_dcs_host_driver.sv
// Bench for dcs_host_driver: schedule-based model of the expected port timeline plus a DCSformer
// result model; one negedge process compares every output every cycle.
module tb_dcs_host_driver;

    localparam int Tmo = 16;
`ifdef DCS_HOST_TIMEOUT_EN
    localparam int MaxWDel = 12;
`else
    localparam int MaxWDel = 40;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_we = 1'b0, ld_sel = 1'b0, start = 1'b0;
    logic [6:0]  ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic [2:0]  res_addr = '0;
    logic        acc_w_ready = 1'b0, acc_o_valid = 1'b0;
    logic [31:0] acc_o_data = '0;
    logic        busy, done, err, i_valid, w_valid;
    logic [7:0]  i_data, w_data;
    logic [31:0] res_data;

    // Expected outputs for the current cycle.
    logic        exp_busy = 1'b0, exp_done = 1'b0, exp_err = 1'b0, exp_iv = 1'b0, exp_wv = 1'b0;
    logic [7:0]  exp_id = '0, exp_wd = '0;
    logic [31:0] exp_bank [8] = '{default: '0};
    logic        err_sticky = 1'b0;

    logic [7:0]  i_mem [128];
    logic [7:0]  w_mem [8];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dcs_host_driver #(.TIMEOUT_CYC(Tmo)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_we_i      (ld_we),
        .ld_sel_i     (ld_sel),
        .ld_addr_i    (ld_addr),
        .ld_data_i    (ld_data),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .res_addr_i   (res_addr),
        .res_data_o   (res_data),
        .acc_i_valid_o(i_valid),
        .acc_i_data_o (i_data),
        .acc_w_ready_i(acc_w_ready),
        .acc_w_valid_o(w_valid),
        .acc_w_data_o (w_data),
        .acc_o_valid_i(acc_o_valid),
        .acc_o_data_i (acc_o_data)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, got, exp);
    endtask

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(exp_busy));
        check("done", 32'(done), 32'(exp_done));
        check("err", 32'(err), 32'(exp_err));
        check("i_valid", 32'(i_valid), 32'(exp_iv));
        check("i_data", 32'(i_data), 32'(exp_id));
        check("w_valid", 32'(w_valid), 32'(exp_wv));
        check("w_data", 32'(w_data), 32'(exp_wd));
        check("res_data", res_data, exp_bank[res_addr]);
    end

    // DCSformer model: G = I*I^T, entries below the integer mean dropped, result = G' * W.
    function automatic logic [31:0] calc_res(input int r);
        longint g [8][8];
        longint tot, avg, acc;
        tot = 0;
        acc = 0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                g[a][b] = 0;
                for (int c = 0; c < 16; c++) g[a][b] += longint'(i_mem[a*16+c]) * i_mem[b*16+c];
                tot += g[a][b];
            end
        end
        avg = tot / 64;
        for (int j = 0; j < 8; j++) begin
            if (g[r][j] >= avg) acc += g[r][j] * w_mem[j];
        end
        return 32'(acc);
    endfunction

    task automatic set_idle();
        start       = 1'b0;
        ld_we       = 1'b0;
        acc_w_ready = 1'b0;
        acc_o_valid = 1'b0;
        acc_o_data  = $urandom;
        res_addr    = 3'($urandom);
        exp_busy    = 1'b0;
        exp_done    = 1'b0;
        exp_iv      = 1'b0;
        exp_id      = '0;
        exp_wv      = 1'b0;
        exp_wd      = '0;
        exp_err     = err_sticky;
    endtask

    // Idle cycles with stray accelerator handshakes that must be ignored.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            set_idle();
            acc_w_ready = ($urandom_range(0, 3) == 0);
            acc_o_valid = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic drive_load(input bit sel, input int addr, input logic [7:0] d);
        @(posedge clk); #1;
        set_idle();
        ld_we   = 1'b1;
        ld_sel  = sel;
        ld_addr = 7'(addr);
        ld_data = d;
    endtask

    // kind 0: all ones; kind 1: identity I, W = 1..8; otherwise random.
    task automatic load_bufs(input int kind);
        for (int k = 0; k < 128; k++) begin
            case (kind)
                0:       i_mem[k] = 8'd1;
                1:       i_mem[k] = (k / 16 == k % 16) ? 8'd1 : 8'd0;
                default: i_mem[k] = 8'($urandom);
            endcase
            drive_load(1'b0, k, i_mem[k]);
        end
        for (int j = 0; j < 8; j++) begin
            case (kind)
                0:       w_mem[j] = 8'd1;
                1:       w_mem[j] = 8'(j + 1);
                default: w_mem[j] = 8'($urandom);
            endcase
            drive_load(1'b1, j + 8 * $urandom_range(0, 15), w_mem[j]);
        end
        idle(1);
    endtask

    // One job with start at t=0. w_ready comes wdel cycles after the last I byte; word 0 arrives
    // ogap cycles after the last W byte; words from index stall_at on are delayed by stall_len.
    task automatic run_job(input int wdel, input int ogap, input int stall_at, input int stall_len,
                           input bit spur, input int rst_at);
        int          wc, last;
        int          oc [8];
        logic [31:0] rw [8];
        wc = 128 + wdel;
        for (int j = 0; j < 8; j++) begin
            oc[j] = wc + 8 + ogap + j + ((j >= stall_at) ? stall_len : 0);
            rw[j] = calc_res(j);
        end
        last = oc[7];
        for (int t = 0; t <= last + 1; t++) begin
            @(posedge clk); #1;
            for (int j = 0; j < 8; j++) if (oc[j] == t - 1) exp_bank[j] = rw[j];
            set_idle();
            if (t == rst_at) begin
                rst_n      = 1'b0;
                err_sticky = 1'b0;
                exp_err    = 1'b0;
                for (int j = 0; j < 8; j++) exp_bank[j] = '0;
                repeat (2) begin
                    @(posedge clk); #1;
                    set_idle();
                end
                rst_n = 1'b1;
                return;
            end
            start = (t == 0) || (spur && t >= 1 && t <= last && $urandom_range(0, 15) == 0);
            acc_w_ready = (t == wc) || (spur && t >= 1 && t < 128 && $urandom_range(0, 15) == 0);
            for (int j = 0; j < 8; j++) begin
                if (oc[j] == t) begin
                    acc_o_valid = 1'b1;
                    acc_o_data  = rw[j];
                end
            end
            if (!acc_o_valid && spur && t <= wc + 8) acc_o_valid = ($urandom_range(0, 3) == 0);
            if (spur && t >= 1 && t <= last && $urandom_range(0, 7) == 0) begin
                ld_we   = 1'b1;
                ld_sel  = 1'($urandom);
                ld_addr = 7'($urandom);
                ld_data = 8'($urandom);
            end
            exp_busy = (t >= 1 && t <= last);
            exp_done = (t == last + 1);
            exp_iv   = (t >= 1 && t <= 128);
            if (exp_iv) exp_id = i_mem[t-1];
            exp_wv = (t > wc && t <= wc + 8);
            if (exp_wv) exp_wd = w_mem[t-wc-1];
            if (t >= 1) err_sticky = 1'b0;
            exp_err = err_sticky;
        end
    endtask

`ifdef DCS_HOST_TIMEOUT_EN
    task automatic run_timeout();
        int last;
        last = 128 + Tmo;
        for (int t = 0; t <= last + 1; t++) begin
            @(posedge clk); #1;
            set_idle();
            start       = (t == 0);
            acc_o_valid = (t > 0 && $urandom_range(0, 3) == 0);
            exp_busy    = (t >= 1 && t <= last);
            exp_done    = (t == last + 1);
            exp_iv      = (t >= 1 && t <= 128);
            if (exp_iv) exp_id = i_mem[t-1];
            if (t >= 1) err_sticky = 1'b0;
            if (t == last + 1) err_sticky = 1'b1;
            exp_err = err_sticky;
        end
    endtask
`endif

    task automatic pin_res(input string name, input int r, input logic [31:0] val);
        @(posedge clk); #1;
        set_idle();
        res_addr = 3'(r);
        @(negedge clk);
        check(name, res_data, val);
    endtask

    initial begin
        set_idle();
        @(negedge clk);
        check("reset_outputs", {26'd0, busy, done, err, i_valid, w_valid, 1'b0}, 32'd0);
        check("reset_data", {16'd0, i_data, w_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        load_bufs(0);
        run_job(5, 2, 8, 0, 1'b0, -1);
        for (int r = 0; r < 8; r++) pin_res("ones_result", r, 32'd128);

        load_bufs(1);
        run_job(0, 1, 8, 0, 1'b0, -1);
        for (int r = 0; r < 8; r++) pin_res("diag_result", r, 32'(r + 1));

        load_bufs(2);
        run_job(MaxWDel, 3, 4, 3, 1'b1, -1);
        run_job($urandom_range(0, MaxWDel), 2, 8, 0, 1'b0, -1);

        run_job(7, 2, 8, 0, 1'b0, 61);
        idle(2);
        run_job(3, 2, 8, 0, 1'b0, -1);

        for (int n = 0; n < 3; n++) begin
            load_bufs(2);
            run_job($urandom_range(0, MaxWDel), $urandom_range(1, 8), $urandom_range(1, 8),
                    $urandom_range(0, 4), 1'b1, -1);
            idle($urandom_range(0, 3));
        end

`ifdef DCS_HOST_TIMEOUT_EN
        run_timeout();
        idle(3);
        run_job(2, 2, 8, 0, 1'b0, -1);
`endif

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
